// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmit controller.
//   state_e        : controller FSM state encoding (two-state binary)
//   PISO_DEFAULT_N : default serialized word width
//   clog2()        : bit-counter width for a given word width (minimum 1)
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int PISO_DEFAULT_N = 8;

  // ceil(log2(value)), never less than 1 so a counter always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register datapath.
//   CLK         : clock, rising edge
//   ASYNCRESETN : asynchronous active-low reset, clears the register
//   load        : capture pi (wins over shift)
//   shift       : shift left by one, FILL entering bit 0
//   pi[N-1:0]   : parallel input word
//   o           : MSB of the register (serial output)
module piso_shift_reg #(
  parameter int   N    = 8,
  parameter logic FILL = 1'b0
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] pi,
  output logic         o
);

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  // Each bit picks the parallel input or its lower neighbour, then holds.
  always_comb begin
    sr_d = sr_q;
    for (int i = 0; i < N; i++) begin
      if (load) begin
        sr_d[i] = pi[i];
      end else if (shift) begin
        sr_d[i] = (i == 0) ? FILL : sr_q[(i == 0) ? 0 : i - 1];
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o = sr_q[N-1];

endmodule

// File: rtl/piso_tx_controller.sv
// PISO transmit controller: ready/valid word intake, MSB-first serialization
// with stall, frame markers and back-to-back word support.
//   CLK, ASYNCRESETN   : clock and asynchronous active-low reset
//   data_in[N-1:0]     : parallel word
//   data_valid         : data_in offered
//   data_ready         : word accepted this cycle when data_valid is also high
//   stall              : freezes serialization while in SHIFT
//   sout, sout_valid   : serial bit and its qualifier
//   sof, eof           : first / last bit of a word
//   busy               : FSM is in SHIFT
module piso_tx_controller
  import piso_pkg::*;
#(
  parameter int   N    = PISO_DEFAULT_N,
  parameter logic FILL = 1'b0
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic [N-1:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic         stall,
  output logic         sout,
  output logic         sout_valid,
  output logic         sof,
  output logic         eof,
  output logic         busy
);

  localparam int            CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          at_last;
  logic          xfer;
  logic          shift_en;

  assign busy    = (state_q == SHIFT);
  assign at_last = (bit_cnt_q == LAST);

  // Ready in IDLE, or on the final unstalled bit so the next word can
  // follow with no gap cycle.
  assign data_ready = !busy || (!stall && at_last);
  assign xfer       = data_valid && data_ready;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (at_last) begin
            if (xfer) begin
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_en  = 1'b1;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  piso_shift_reg #(
    .N   (N),
    .FILL(FILL)
  ) u_shift_reg (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .load       (xfer),
    .shift      (shift_en),
    .pi         (data_in),
    .o          (sout)
  );

  assign sout_valid = busy && !stall;
  assign sof        = sout_valid && (bit_cnt_q == '0);
  assign eof        = sout_valid && at_last;

endmodule

// File: tb/tb_piso_tx_controller.sv
module tb_piso_tx_controller;

  logic       CLK;
  logic       ASYNCRESETN;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       stall;
  logic       sout;
  logic       sout_valid;
  logic       sof;
  logic       eof;
  logic       busy;

  int errors;
  int checks;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       stall;
    logic       ready;
    logic       sout;
    logic       svalid;
    logic       sof;
    logic       eof;
    logic       busy;
  } vec_t;

  vec_t vec[$];

  piso_tx_controller #(
    .N   (8),
    .FILL(1'b0)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .stall      (stall),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sof        (sof),
    .eof        (eof),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic ready, input logic so, input logic sv,
                         input logic sf, input logic ef, input logic bz);
    chk("data_ready", idx, data_ready, ready);
    chk("sout",       idx, sout,       so);
    chk("sout_valid", idx, sout_valid, sv);
    chk("sof",        idx, sof,        sf);
    chk("eof",        idx, eof,        ef);
    chk("busy",       idx, busy,       bz);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic s, input logic r,
                     input logic so, input logic sv, input logic sf, input logic ef,
                     input logic bz);
    vec_t t;
    t.valid = v; t.data = d; t.stall = s; t.ready = r;
    t.sout = so; t.svalid = sv; t.sof = sf; t.eof = ef; t.busy = bz;
    vec.push_back(t);
  endtask

  // Called at posedge+1: drive, settle, compare, advance to next posedge+1.
  task automatic run_vec(input int base);
    for (int i = 0; i < vec.size(); i++) begin
      data_valid = vec[i].valid;
      data_in    = vec[i].data;
      stall      = vec[i].stall;
      #3;
      chk_all(base + i, vec[i].ready, vec[i].sout, vec[i].svalid,
              vec[i].sof, vec[i].eof, vec[i].busy);
      @(posedge CLK);
      #1;
    end
  endtask

  // Eight serialized bits of word w, plain (no stall), MSB first.
  task automatic add_word(input logic [7:0] w, input logic v, input logic [7:0] nd,
                          input logic nv_last);
    for (int i = 0; i < 8; i++) begin
      add((i == 7) ? nv_last : v, nd, 1'b0, (i == 7), w[7-i], 1'b1, (i == 0), (i == 7), 1'b1);
    end
  endtask

  initial begin
    logic [7:0] w;
    errors      = 0;
    checks      = 0;
    ASYNCRESETN = 1'b0;
    data_valid  = 1'b0;
    data_in     = 8'h00;
    stall       = 1'b0;

    // Reset values, with stall high to show it does not affect IDLE outputs.
    #2;
    stall = 1'b1;
    #1;
    chk_all(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;

    // Single word 0xA5
    add(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_word(8'hA5, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back 0xF0 then 0x0F with valid held
    add(1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_word(8'hF0, 1'b1, 8'h0F, 1'b1);
    add_word(8'h0F, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // 0xC3 with 3 stall cycles after bit 2; eof 11 cycles after transfer
    w = 8'hC3;
    add(1'b1, w, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, w[7], 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, w[6], 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b1, 1'b0, w[5], 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i < 8; i++)
      add(1'b0, 8'h00, 1'b0, (i == 7), w[7-i], 1'b1, 1'b0, (i == 7), 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall on the last bit of 0x5A with the next word 0x3C waiting
    w = 8'h5A;
    add(1'b1, w, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      add(1'b0, 8'h00, 1'b0, 1'b0, w[7-i], 1'b1, (i == 0), 1'b0, 1'b1);
    add(1'b1, 8'h3C, 1'b1, 1'b0, w[0], 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h3C, 1'b0, 1'b1, w[0], 1'b1, 1'b0, 1'b1, 1'b1);
    add_word(8'h3C, 1'b0, 8'h00, 1'b0);
    // IDLE ignores stall, and accepts a transfer while stall is high
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_word(8'h99, 1'b0, 8'h00, 1'b0);

    // Idle hygiene with random data/stall; register keeps last bit of 0x99
    for (int i = 0; i < 20; i++)
      add(1'b0, 8'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    run_vec(100);

    // Reset mid-word on 0xFF after bit 3
    data_valid = 1'b1;
    data_in    = 8'hFF;
    stall      = 1'b0;
    @(posedge CLK);
    #1;
    data_valid = 1'b0;
    data_in    = 8'($urandom);
    #3;
    chk_all(500, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge CLK);
    #4;
    chk_all(501, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    #4;
    chk_all(502, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk_all(503, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #3;
    ASYNCRESETN = 1'b1;
    #1;
    chk_all(504, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;

    vec.delete();
    for (int i = 0; i < 3; i++)
      add(1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_word(8'h81, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
